// File: rtl/axis_rr_packet_arbiter.sv
// axis_rr_packet_arbiter
// Packet-granular round-robin multiplexer of NUM_IN AXI-Stream sources onto a
// single AXI-Stream sink. No storage: the granted source is steered to the sink
// combinationally, and every other source sees tready=0 until the owner's tlast
// beat has been accepted.
//
// Optional idle-lock timeout: define AXIS_ARB_TIMEOUT_EN to release a lock whose
// owner has held tvalid low for TIMEOUT_CYCLES consecutive cycles.
//
// Handshake: a beat moves on a cycle where tvalid and tready are both high on the
// same interface. The arbiter never touches a source's tvalid/tdata/tlast; it only
// chooses which source reaches the sink and gates each source's tready.
//
// FSM state is visible on grant_valid (high exactly while LOCKED).
module axis_rr_packet_arbiter #(
    parameter int NUM_IN         = 2,
    parameter int AXIS_BYTES     = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           sresetn,
    output logic [NUM_IN-1:0]              s_axis_tready,
    input  logic [NUM_IN-1:0]              s_axis_tvalid,
    input  logic [NUM_IN-1:0]              s_axis_tlast,
    input  logic [NUM_IN*8*AXIS_BYTES-1:0] s_axis_tdata,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tvalid,
    output logic                           m_axis_tlast,
    output logic [8*AXIS_BYTES-1:0]        m_axis_tdata,
    output logic                           grant_valid,
    output logic [$clog2(NUM_IN)-1:0]      grant_idx,
    output logic                           timeout_pulse
);

    localparam int            DW       = 8 * AXIS_BYTES;
    localparam int            IW       = $clog2(NUM_IN);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_IN - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] ptr;
    logic [IW-1:0] ptr_nxt;
    logic [IW-1:0] idx_nxt;
    logic [IW-1:0] sel;
    logic [IW-1:0] grant_inc;
    logic          any_req;
    logic          fwd_valid;
    logic          fwd_last;
    logic [DW-1:0] fwd_data;
    logic          tmo;

    if (NUM_IN < 2 || NUM_IN > 8) begin : g_chk_num_in
        $error("axis_rr_packet_arbiter: NUM_IN must be within 2..8");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_chk_timeout
        $error("axis_rr_packet_arbiter: TIMEOUT_CYCLES must be at least 2");
    end

    // Round-robin pick: the requesting source closest at-or-after the pointer.
    // Offsets are walked from farthest to nearest so the nearest one wins.
    always_comb begin
        sel     = '0;
        any_req = 1'b0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (s_axis_tvalid[i] &&
                    ((int'(ptr) + k == i) || (int'(ptr) + k == i + NUM_IN))) begin
                    sel     = IW'(i);
                    any_req = 1'b1;
                end
            end
        end
    end

    // Steer the granted source's beat toward the sink side.
    always_comb begin
        fwd_valid = 1'b0;
        fwd_last  = 1'b0;
        fwd_data  = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_idx == IW'(i)) begin
                fwd_valid = s_axis_tvalid[i];
                fwd_last  = s_axis_tlast[i];
                fwd_data  = s_axis_tdata[i*DW +: DW];
            end
        end
    end

    // Next state, pointer advance and per-state output gating.
    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        idx_nxt       = grant_idx;
        grant_inc     = (grant_idx == LAST_IDX) ? '0 : grant_idx + IW'(1);
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;
        s_axis_tready = '0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = LOCKED;
                    idx_nxt   = sel;
                end
            end
            LOCKED: begin
                m_axis_tvalid = fwd_valid;
                m_axis_tlast  = fwd_last;
                m_axis_tdata  = fwd_data;
                for (int i = 0; i < NUM_IN; i++) begin
                    s_axis_tready[i] = (grant_idx == IW'(i)) && m_axis_tready;
                end
                // Release after the owner's tlast beat, or when the owner stalls out.
                if ((fwd_valid && m_axis_tready && fwd_last) || tmo) begin
                    state_nxt = IDLE;
                    ptr_nxt   = grant_inc;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, round-robin pointer and grant index registers.
    always_ff @(posedge clk) begin
        if (!sresetn) begin
            state     <= IDLE;
            ptr       <= '0;
            grant_idx <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            grant_idx <= idx_nxt;
        end
    end

    assign grant_valid = (state == LOCKED);

`ifdef AXIS_ARB_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYCLES);

    logic [TCW-1:0] tcnt;

    // Expiry: the owner has now been silent for TIMEOUT_CYCLES cycles in a row.
    assign tmo = (state == LOCKED) && !fwd_valid &&
                 (tcnt == TCW'(TIMEOUT_CYCLES - 1));

    // Count consecutive silent cycles of the owner; any beat, expiry or IDLE clears.
    always_ff @(posedge clk) begin
        if (!sresetn || (state != LOCKED) || fwd_valid || tmo) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + TCW'(1);
        end
    end

    assign timeout_pulse = tmo;
`else
    assign tmo           = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
// Bench for axis_rr_packet_arbiter (NUM_IN=3, AXIS_BYTES=1, TIMEOUT_CYCLES=16).
// Sources replay per-source beat lists; a round-robin/packet-lock reference model
// predicts grants and the exact beat stream on the sink. Works with or without
// AXIS_ARB_TIMEOUT_EN defined.
`timescale 1ns/1ps
module tb_axis_rr_packet_arbiter;

    localparam int N     = 3;
    localparam int DW    = 8;
    localparam int TMO   = 16;
    localparam int IW    = $clog2(N);
    localparam int DEPTH = 128;

    // ---------------- clock / reset / DUT ----------------
    logic          clk;
    logic          sresetn;
    logic [N-1:0]  s_tready;
    logic [N-1:0]  s_tvalid;
    logic [N-1:0]  s_tlast;
    logic [N*DW-1:0] s_tdata;
    logic          m_tready;
    logic          m_tvalid;
    logic          m_tlast;
    logic [DW-1:0] m_tdata;
    logic          grant_valid;
    logic [IW-1:0] grant_idx;
    logic          timeout_pulse;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    axis_rr_packet_arbiter #(
        .NUM_IN(N),
        .AXIS_BYTES(1),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .sresetn(sresetn),
        .s_axis_tready(s_tready),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast),
        .s_axis_tdata(s_tdata),
        .m_axis_tready(m_tready),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tlast(m_tlast),
        .m_axis_tdata(m_tdata),
        .grant_valid(grant_valid),
        .grant_idx(grant_idx),
        .timeout_pulse(timeout_pulse)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- source and model state ----------------
    logic [8:0] src_mem [N][DEPTH];   // {last, data}
    int         src_wr [N];
    int         src_rd [N];
    bit         presenting [N];
    bit         hs [N];
    int         hold_off [N];
    bit         rand_mode;
    bit         rdy_pat [$];

    logic [8:0] exp_q [$];            // expected sink beats {last, data}
    bit         mdl_locked;
    int         mdl_g;
    int         mdl_ptr;
    int         mdl_idle;
    int         gnt_log [$];
    int         beats_out;
    int         pulse_seen;
    bit         prev_stall;
    logic [8:0] prev_beat;

    int tests;
    int fails;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic add_pkt(input int src, input int len, input int base, input bit with_last);
        for (int k = 0; k < len; k++) begin
            src_mem[src][src_wr[src]] = {(with_last && (k == len - 1)), 8'(base + k)};
            src_wr[src]++;
        end
    endtask

    function automatic bit drained();
        bit d;
        d = !mdl_locked && (exp_q.size() == 0);
        for (int i = 0; i < N; i++) begin
            if (src_rd[i] != src_wr[i] || presenting[i]) d = 1'b0;
        end
        return d;
    endfunction

    // ---------------- driver (posedge + 1) ----------------
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                src_rd[i]++;
                presenting[i] = 1'b0;
                hs[i] = 1'b0;
            end
            if (!presenting[i] && src_rd[i] < src_wr[i]) begin
                if (hold_off[i] > 0) hold_off[i]--;
                else if (!rand_mode || $urandom_range(0, 3) != 0) presenting[i] = 1'b1;
            end
            s_tvalid[i] = presenting[i];
            if (presenting[i]) begin
                s_tlast[i]             = src_mem[i][src_rd[i]][8];
                s_tdata[i*DW +: DW]    = src_mem[i][src_rd[i]][7:0];
            end else begin
                s_tlast[i]             = 1'b0;
                s_tdata[i*DW +: DW]    = '0;
            end
        end
        if (rdy_pat.size() > 0) m_tready = rdy_pat.pop_front();
        else if (rand_mode)     m_tready = ($urandom_range(0, 3) != 0);
        else                    m_tready = 1'b1;
    endtask

    // ---------------- reference model + scoreboard (negedge) ----------------
    task automatic observe();
        logic [8:0]   beat;
        logic [N-1:0] exp_rdy;
        logic [8:0]   exp_b;
        int           sel;
        beat = {m_tlast, m_tdata};
        for (int i = 0; i < N; i++) hs[i] = s_tvalid[i] && s_tready[i];
        if (timeout_pulse) pulse_seen++;
        if (!mdl_locked) begin
            chk("idle_m_valid", 32'(m_tvalid), 0);
            chk("idle_s_ready", 32'(s_tready), 0);
            chk("idle_grant_valid", 32'(grant_valid), 0);
            chk("idle_m_data", 32'(m_tdata), 0);
            chk("idle_pulse", 32'(timeout_pulse), 0);
            prev_stall = 1'b0;
            sel = -1;
            for (int k = 0; k < N; k++) begin
                int j;
                j = (mdl_ptr + k) % N;
                if (sel < 0 && s_tvalid[j]) sel = j;
            end
            if (sel >= 0) begin
                mdl_locked = 1'b1;
                mdl_g      = sel;
                mdl_idle   = 0;
                gnt_log.push_back(sel);
                for (int p = src_rd[sel]; p < src_wr[sel]; p++) begin
                    exp_q.push_back(src_mem[sel][p]);
                    if (src_mem[sel][p][8]) break;
                end
            end
        end else begin
            chk("lock_grant_valid", 32'(grant_valid), 1);
            chk("lock_grant_idx", 32'(grant_idx), 32'(mdl_g));
            chk("lock_m_valid", 32'(m_tvalid), 32'(s_tvalid[mdl_g]));
            exp_rdy = '0;
            exp_rdy[mdl_g] = m_tready;
            chk("lock_s_ready", 32'(s_tready), 32'(exp_rdy));
            if (prev_stall) chk("stall_hold", 32'(beat), 32'(prev_beat));
            if (m_tvalid && m_tready) begin
                chk("xfer_pulse", 32'(timeout_pulse), 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    exp_b = exp_q.pop_front();
                    chk("beat", 32'(beat), 32'(exp_b));
                end
                beats_out++;
                prev_stall = 1'b0;
                mdl_idle   = 0;
                if (m_tlast) begin
                    mdl_locked = 1'b0;
                    mdl_ptr    = (mdl_g + 1) % N;
                end
            end else begin
                prev_stall = m_tvalid;
                prev_beat  = beat;
                if (!s_tvalid[mdl_g]) mdl_idle++;
                else                  mdl_idle = 0;
`ifdef AXIS_ARB_TIMEOUT_EN
                if (mdl_idle == TMO) begin
                    chk("timeout_pulse", 32'(timeout_pulse), 1);
                    mdl_locked = 1'b0;
                    mdl_ptr    = (mdl_g + 1) % N;
                    exp_q.delete();
                    prev_stall = 1'b0;
                end else begin
                    chk("no_pulse", 32'(timeout_pulse), 0);
                end
`else
                chk("no_pulse", 32'(timeout_pulse), 0);
`endif
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk); #1;
        drive();
        @(negedge clk);
        observe();
    endtask

    task automatic run_until_drained(input string tag, input int budget, output int used);
        used = 0;
        do begin
            cycle();
            used++;
        end while (!drained() && used < budget);
        chk({tag, "_drained"}, 32'(drained()), 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        sresetn  = 1'b0;
        for (int i = 0; i < N; i++) begin
            src_rd[i]     = src_wr[i];
            presenting[i] = 1'b0;
            hs[i]         = 1'b0;
            hold_off[i]   = 0;
        end
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        m_tready = 1'b1;
        exp_q.delete();
        rdy_pat.delete();
        @(posedge clk); #1;
        sresetn    = 1'b1;
        mdl_locked = 1'b0;
        mdl_ptr    = 0;
        mdl_idle   = 0;
        prev_stall = 1'b0;
        @(negedge clk);
        chk("rst_grant_idx", 32'(grant_idx), 0);
        chk("rst_grant_valid", 32'(grant_valid), 0);
        chk("rst_m_tlast", 32'(m_tlast), 0);
        observe();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int used;
        int beats0;
        int total;
        int len;
        tests = 0; fails = 0;
        beats_out = 0; pulse_seen = 0;
        rand_mode = 1'b0;
        sresetn = 1'b0; m_tready = 1'b1;
        s_tvalid = '0; s_tlast = '0; s_tdata = '0;
        mdl_locked = 1'b0; mdl_g = 0; mdl_ptr = 0; mdl_idle = 0;
        prev_stall = 1'b0; prev_beat = '0;
        for (int i = 0; i < N; i++) begin
            src_wr[i] = 0; src_rd[i] = 0; presenting[i] = 1'b0;
            hs[i] = 1'b0; hold_off[i] = 0;
        end
        repeat (3) @(posedge clk);
        do_reset();

        // 1: single 3-beat packet from source 0, sink always ready
        beats0 = beats_out;
        add_pkt(0, 3, 8'hA1, 1'b1);
        run_until_drained("t1", 20, used);
        chk("t1_cycles", 32'(used), 5);
        chk("t1_beats", 32'(beats_out - beats0), 3);
        chk("t1_gnt_n", 32'(gnt_log.size()), 1);
        if (gnt_log.size() > 0) chk("t1_gnt", 32'(gnt_log[0]), 0);
        chk("t1_grant_idx_held", 32'(grant_idx), 0);

        // 2: sources 0 and 1 continuously send 1-beat packets
        do_reset();
        gnt_log.delete();
        for (int p = 0; p < 4; p++) begin
            add_pkt(0, 1, 8'h10 + p, 1'b1);
            add_pkt(1, 1, 8'h20 + p, 1'b1);
        end
        run_until_drained("t2", 40, used);
        chk("t2_cycles", 32'(used), 17);
        chk("t2_gnt_n", 32'(gnt_log.size()), 8);
        for (int k = 0; k < 8 && k < gnt_log.size(); k++) chk("t2_gnt", 32'(gnt_log[k]), 32'(k % 2));

        // 3: source 1 requests in the middle of a 4-beat source 0 packet
        gnt_log.delete();
        add_pkt(0, 4, 8'h30, 1'b1);
        add_pkt(1, 2, 8'h40, 1'b1);
        hold_off[1] = 2;
        run_until_drained("t3", 40, used);
        chk("t3_gnt_n", 32'(gnt_log.size()), 2);
        if (gnt_log.size() == 2) begin
            chk("t3_gnt0", 32'(gnt_log[0]), 0);
            chk("t3_gnt1", 32'(gnt_log[1]), 1);
        end

        // 4: sink stalls mid-packet (ready 1,0,0,1)
        gnt_log.delete();
        add_pkt(0, 4, 8'h50, 1'b1);
        rdy_pat.push_back(1'b1); rdy_pat.push_back(1'b1);
        rdy_pat.push_back(1'b0); rdy_pat.push_back(1'b0);
        rdy_pat.push_back(1'b1);
        run_until_drained("t4", 40, used);
        chk("t4_cycles", 32'(used), 8);
        chk("t4_gnt_n", 32'(gnt_log.size()), 1);

        // 5: reset in the middle of a source 1 packet, then pointer restarts at 0
        add_pkt(1, 4, 8'h60, 1'b1);
        repeat (3) cycle();
        chk("t5_locked_src1", 32'(grant_idx), 1);
        do_reset();
        chk("t5_post_rst_valid", 32'(m_tvalid), 0);
        gnt_log.delete();
        add_pkt(0, 2, 8'h70, 1'b1);
        add_pkt(1, 2, 8'h80, 1'b1);
        run_until_drained("t5", 40, used);
        chk("t5_gnt_n", 32'(gnt_log.size()), 2);
        if (gnt_log.size() == 2) begin
            chk("t5_gnt0", 32'(gnt_log[0]), 0);
            chk("t5_gnt1", 32'(gnt_log[1]), 1);
        end

        // 6: source 0 stalls after a beat without tlast while source 1 waits
        gnt_log.delete();
        pulse_seen = 0;
        add_pkt(0, 1, 8'h90, 1'b0);
        add_pkt(1, 1, 8'h95, 1'b1);
        hold_off[1] = 2;
`ifdef AXIS_ARB_TIMEOUT_EN
        run_until_drained("t6", 60, used);
        chk("t6_cycles", 32'(used), 21);
        chk("t6_pulses", 32'(pulse_seen), 1);
        chk("t6_gnt_n", 32'(gnt_log.size()), 2);
        if (gnt_log.size() == 2) chk("t6_gnt1", 32'(gnt_log[1]), 1);
`else
        repeat (40) cycle();
        chk("t6_pulses", 32'(pulse_seen), 0);
        chk("t6_gnt_n", 32'(gnt_log.size()), 1);
        chk("t6_still_locked", 32'(grant_valid), 1);
        chk("t6_grant_idx", 32'(grant_idx), 0);
`endif
        do_reset();

        // 7: randomized packets, gaps and sink back-pressure on all sources
        rand_mode = 1'b1;
        gnt_log.delete();
        beats0 = beats_out;
        total  = 0;
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < N; i++) begin
                len = $urandom_range(1, 5);
                add_pkt(i, len, $urandom_range(0, 255), 1'b1);
                total += len;
            end
        end
        run_until_drained("rand", 3000, used);
        chk("rand_beats", 32'(beats_out - beats0), 32'(total));
        chk("rand_gnt_n", 32'(gnt_log.size()), 32'(6 * N));
        chk("rand_exp_empty", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axis_rr_packet_arbiter.md
Name: axis_rr_packet_arbiter

Overview:
- Shares one AXI-Stream sink between NUM_IN AXI-Stream sources, e.g. a single uart_tx fed by both the echo FIFO and a status/response generator in the bootstrap loader.
- Round-robin arbitration at packet granularity: once a source is granted, it owns the output until its tlast beat completes.
- Pure flow-control block: no data storage, no data modification.

Parameters:
- NUM_IN, 2, number of source streams (2..8).
- AXIS_BYTES, 1, data bytes per beat; tdata width = 8*AXIS_BYTES.
- TIMEOUT_CYCLES, 1024, idle-lock timeout; used only when AXIS_ARB_TIMEOUT_EN is defined.

Ports:
- clk  input  1  clock.
- sresetn  input  1  synchronous reset, active-low.
- s_axis_tready  output  NUM_IN  per-source ready.
- s_axis_tvalid  input  NUM_IN  per-source valid.
- s_axis_tlast  input  NUM_IN  per-source last.
- s_axis_tdata  input  NUM_IN*8*AXIS_BYTES  source i occupies bits [i*8*AXIS_BYTES +: 8*AXIS_BYTES].
- m_axis_tready  input  1  sink ready.
- m_axis_tvalid  output  1  sink valid.
- m_axis_tlast  output  1  sink last.
- m_axis_tdata  output  8*AXIS_BYTES  sink data.
- grant_valid  output  1  high while a source holds the output.
- grant_idx  output  $clog2(NUM_IN)  index of the current/last granted source.
- timeout_pulse  output  1  one-cycle strobe on lock timeout; tied 0 when the feature is absent.

Behaviour:
- Reset (sresetn low at a clock edge):
  - state=IDLE, pointer=0, grant_idx=0, grant_valid=0, timeout counter=0.
  - All s_axis_tready=0; m_axis_tvalid=0; m_axis_tlast=0; m_axis_tdata=0.
  - Reset mid-packet abandons the packet; no further beats are forwarded.
- States: IDLE, LOCKED.
- IDLE:
  - All s_axis_tready=0; m_axis_tvalid=0.
  - If any s_axis_tvalid is high, select the first valid source scanning upward from pointer, wrapping NUM_IN-1 -> 0.
  - Register the selection: grant_idx<=sel, grant_valid<=1, state<=LOCKED.
  - Arbitration latency: 1 cycle from request to first possible transfer.
- LOCKED (g = grant_idx):
  - Combinational forwarding: m_axis_tvalid=s_axis_tvalid[g], m_axis_tlast=s_axis_tlast[g], m_axis_tdata=slice g, s_axis_tready[g]=m_axis_tready.
  - All other s_axis_tready=0.
  - A transfer occurs when m_axis_tvalid && m_axis_tready.
  - Transfer with tlast=1: state<=IDLE, grant_valid<=0, pointer<=(g+1) mod NUM_IN. grant_idx holds its value.
  - Requests from other sources are ignored until the packet ends (packet lock).
  - m_axis_tdata in IDLE: 0.
- Bubble: exactly 1 idle output cycle between consecutive packets, including back-to-back packets from the same source.
- Fairness:
  - With all sources continuously requesting, grants rotate 0,1,..,NUM_IN-1,0,...
  - A lone requester is re-granted every packet.
- Wrap: pointer increments modulo NUM_IN, also for non-power-of-2 NUM_IN.
- Single-beat packet (tlast on first beat): LOCKED lasts only until that transfer.
- Sources obey AXIS rules: tvalid is not withdrawn before handshake. The arbiter does not check this.

Optional Feature:
- Macro: AXIS_ARB_TIMEOUT_EN.
- Defined:
  - In LOCKED, a counter increments every cycle s_axis_tvalid[g]=0 and clears on any cycle it is 1.
  - When the counter reaches TIMEOUT_CYCLES-1 with tvalid still 0:
    - state<=IDLE, grant_valid<=0, pointer<=(g+1) mod NUM_IN, counter<=0.
    - timeout_pulse=1 for that one cycle.
  - The stalled source's packet is truncated; no tlast is emitted.
- Not defined:
  - No counter logic.
  - Lock is held indefinitely until tlast.
  - timeout_pulse is constant 0.

Test Plan:
- NUM_IN=2, source0 sends 3-beat packet 0xA1,0xA2,0xA3(last), m_axis_tready=1 -> first m beat 1 cycle after tvalid; beats appear consecutively with tlast on 0xA3; grant_idx=0; return to IDLE.
- Both sources request continuously with 1-beat packets -> output order src0,src1,src0,src1, 1 bubble between each; grant_idx alternates 0,1.
- Source1 raises tvalid during beat 2 of a 4-beat src0 packet -> s_axis_tready[1]=0 until src0's tlast; src1 is granted next.
- m_axis_tready toggled 1,0,0,1 mid-packet -> data held stable while stalled; no beat lost or duplicated; s_axis_tready[g] mirrors m_axis_tready.
- sresetn low for 1 cycle mid-packet -> next cycle all outputs 0, state IDLE; after release, source0 is granted first (pointer=0).
- AXIS_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, src0 sends 1 beat without tlast then drops tvalid while src1 requests -> timeout_pulse high on 16th idle cycle; src1 granted next cycle after; with macro off, src1 is never granted.
